// File: rtl/sqrt_lut_arbiter.sv
// Round-robin arbiter that shares one combinational Q8.8 square-root LUT among
// NREQ requesters. It performs one lookup per cycle and returns each result on a registered one-hot response.
module sqrt_lut_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  busy,
  output logic [15:0]           lookup_cnt
);

  // floor(sqrt(idx) * 256), where idx is the integer byte of a Q8.8 operand.
  // The largest root is 4087, so 12 result bits are enough.
  function automatic logic [WIDTH-1:0] sqrt_q88(input int unsigned idx);
    longint unsigned rad;
    longint unsigned root;
    longint unsigned trial;
    rad  = idx;
    rad  = rad << 16;
    root = 0;
    for (int b = 11; b >= 0; b--) begin
      trial = root | (64'd1 << b);
      if (trial * trial <= rad) root = trial;
    end
    return WIDTH'(root);
  endfunction

  logic [WIDTH-1:0] sqrt_lut [256];
  for (genvar i = 0; i < 256; i++) begin : g_lut
    assign sqrt_lut[i] = sqrt_q88(i);
  end

  logic [WIDTH-1:0] req_op [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_op
    assign req_op[i] = req_data[i*WIDTH +: WIDTH];
  end

  logic             out_valid;
  logic [IDW-1:0]   out_id;
  logic [WIDTH-1:0] out_data;
  logic [IDW-1:0]   last;

  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   grant;
  logic             grant_found;
  logic             can_issue;
  logic             accept;
  logic [7:0]       lut_idx;

  // Rotating search: the candidate after the last grant gets first priority.
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    grant_found = 1'b0;
    grant       = last;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign can_issue = !out_valid || rsp_ready[out_id];
  assign accept    = can_issue && grant_found;
  assign lut_idx   = req_op[grant][WIDTH-1 -: 8];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (out_valid) rsp_valid[out_id] = 1'b1;
  end

  assign rsp_data = out_data;
  assign busy     = out_valid || (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking (<=) everywhere here, so each register sees pre-edge values.
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_data   <= '0;
      last       <= IDW'(NREQ - 1);
      lookup_cnt <= 16'd0;
    end else if (accept) begin
      out_data   <= sqrt_lut[lut_idx];
      out_id     <= grant;
      out_valid  <= 1'b1;
      last       <= grant;
      lookup_cnt <= lookup_cnt + 16'd1;
    end else if (out_valid && rsp_ready[out_id]) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sqrt_lut_arbiter.sv
// Self-checking bench for sqrt_lut_arbiter. A spec-level model pushes expected
// responses into a queue, and a separate monitor pops them and compares them with the DUT.
module tb_sqrt_lut_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [NREQ-1:0]       rsp_ready;
  logic                  busy;
  logic [15:0]           lookup_cnt;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] rr_ops [NREQ] = '{16'h0100, 16'h0400, 16'h0900, 16'h1000};
  logic [15:0] rr_exp [NREQ] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};

  // Model state, written only by the model process.
  logic        m_valid;
  int          m_id;
  int          m_last;
  logic [15:0] m_cnt;

  sqrt_lut_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .lookup_cnt (lookup_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Largest r with r*r <= (integer part << 16), found from a floating-point estimate.
  function automatic logic [15:0] sqrt_ref(input logic [15:0] operand);
    longint v;
    longint r;
    v = longint'(operand[15:8]) * 65536;
    r = longint'($floor($sqrt(real'(v))));
    while ((r + 1) * (r + 1) <= v) r++;
    while (r * r > v) r--;
    return 16'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] d);
    req_valid[i] = v;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    tick();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Reference model: grants, counter and busy, plus expectation pushes.
  initial begin : model
    int              g;
    int              j;
    logic            can;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_id    = 0;
        m_last  = NREQ - 1;
        m_cnt   = 16'd0;
        exp_q.delete();
      end else begin
        can = !m_valid || rsp_ready[m_id];
        g   = -1;
        if (can) begin
          for (int k = 1; k <= NREQ; k++) begin
            j = (m_last + k) % NREQ;
            if (g < 0 && req_valid[j]) g = j;
          end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("lookup_cnt", 32'(lookup_cnt), 32'(m_cnt));
        check("busy", 32'(busy), 32'(m_valid || (req_valid != '0)));
        if (g >= 0) begin
          e.id   = g;
          e.data = sqrt_ref(req_data[g*WIDTH +: WIDTH]);
          exp_q.push_back(e);
          m_valid = 1'b1;
          m_id    = g;
          m_last  = g;
          m_cnt   = m_cnt + 16'd1;
        end else if (m_valid && rsp_ready[m_id]) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every presented response with the oldest expectation.
  initial begin : monitor
    int id;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rsp_valid_in_reset", 32'(rsp_valid), 32'(0));
      end else if (rsp_valid != '0) begin
        check("rsp_onehot", 32'($onehot(rsp_valid)), 32'(1));
        id = -1;
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) id = i;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          check("rsp_id", 32'(id), 32'(exp_q[0].id));
          check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
          if (rsp_ready[id]) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [NREQ-1:0] acc;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_rsp_data", 32'(rsp_data), 32'(0));
    check("reset_cnt", 32'(lookup_cnt), 32'(0));
    check("reset_req_ready", 32'(req_ready), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));

    // Single requester.
    tick();
    set_req(2, 1'b1, 16'h0400);
    rsp_ready = '1;
    @(negedge clk);
    check("single_req_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    set_req(2, 1'b0, 16'h0000);
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
    check("single_rsp_data", 32'(rsp_data), 32'(16'h0200));
    check("single_cnt", 32'(lookup_cnt), 32'(1));

    // Round-robin with every requester continuously valid.
    do_reset();
    tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rr_ops[i]);
    for (int k = 0; k <= NREQ; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
      if (k > 0) begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'(1 << ((k - 1) % NREQ)));
        check("rr_rsp_data", 32'(rsp_data), 32'(rr_exp[(k - 1) % NREQ]));
      end
      tick();
    end
    req_valid = '0;

    // Back-pressure on requester 1 while requester 3 waits.
    do_reset();
    tick();
    set_req(1, 1'b1, 16'h1000);
    rsp_ready = '0;
    @(negedge clk);
    check("bp_first_grant", 32'(req_ready), 32'(4'b0010));
    tick();
    set_req(1, 1'b0, 16'h0000);
    set_req(3, 1'b1, 16'h1900);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(req_ready), 32'(0));
      check("bp_stall_valid", 32'(rsp_valid), 32'(4'b0010));
      check("bp_stall_data", 32'(rsp_data), 32'(16'h0400));
      tick();
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    check("bp_release_grant", 32'(req_ready), 32'(4'b1000));
    tick();
    set_req(3, 1'b0, 16'h0000);
    rsp_ready = '1;
    @(negedge clk);
    check("bp_next_valid", 32'(rsp_valid), 32'(4'b1000));
    check("bp_next_data", 32'(rsp_data), 32'(16'h0500));

    // Low byte of the operand is ignored.
    tick();
    set_req(0, 1'b1, 16'h09FF);
    @(negedge clk);
    tick();
    set_req(0, 1'b1, 16'h0900);
    @(negedge clk);
    check("lowbyte_valid", 32'(rsp_valid), 32'(4'b0001));
    check("lowbyte_09ff", 32'(rsp_data), 32'(16'h0300));
    tick();
    set_req(0, 1'b0, 16'h0000);
    @(negedge clk);
    check("lowbyte_0900", 32'(rsp_data), 32'(16'h0300));

    // Randomized traffic obeying the requester contract.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && acc[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 1'b1, 16'($urandom));
          else set_req(i, 1'b0, 16'h0000);
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, 16'($urandom));
        end
      end
      rsp_ready = 4'($urandom) | 4'($urandom);
    end
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) @(negedge clk);
    check("rand_drain", 32'(exp_q.size()), 32'(0));

    // Reset while a response to requester 0 is outstanding.
    tick();
    set_req(0, 1'b1, 16'h0400);
    rsp_ready = '0;
    @(negedge clk);
    tick();
    set_req(0, 1'b0, 16'h0000);
    @(negedge clk);
    check("midrst_pre_valid", 32'(rsp_valid), 32'(4'b0001));
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rr_ops[i]);
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_cnt", 32'(lookup_cnt), 32'(0));
    check("midrst_first_grant", 32'(req_ready), 32'(4'b0001));

    // 65536 back-to-back accepts wrap the counter to zero.
    repeat (65536) @(posedge clk);
    #1;
    @(negedge clk);
    check("wrap_cnt", 32'(lookup_cnt), 32'(16'h0000));
    check("wrap_rsp_valid", 32'(rsp_valid), 32'(4'b1000));
    check("wrap_rsp_data", 32'(rsp_data), 32'(16'h0400));

    tick();
    req_valid = '0;
    repeat (4) @(negedge clk);
    check("final_drain", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
